// File: rtl/pipe_issue_ctrl.sv
// In-order issue controller with RAW hazard bubbles for a no-forwarding pipeline.
// Optional issue/stall statistics counters: define PIPE_ISSUE_STATS_EN.
module pipe_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [3:0]  in_func,
  input  logic [31:0] in_addr,
  output logic        iss_valid,
  output logic [4:0]  iss_rs1,
  output logic [4:0]  iss_rs2,
  output logic [4:0]  iss_rd,
  output logic [3:0]  iss_func,
  output logic [31:0] iss_addr,
  output logic        idle,
  output logic [31:0] issue_count,
  output logic [31:0] stall_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  func;
    logic [31:0] addr;
  } instr_t;

  localparam instr_t BUBBLE = '{
    rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
    func: 4'hF, addr: 32'd0
  };

  instr_t          mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  instr_t          iss_q, iss_d;
  logic            vld_q, vld_d;
  logic [4:0]      h1_q, h2_q;

  instr_t head;
  logic   empty, hit1, hit2, hazard;
  logic   push, pop, stall;

  assign head     = mem_q[rptr_q];
  assign empty    = (count_q == '0);
  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready && !reset;

  // The rd two slots back lands in the register file on the same edge
  // a consumer would be loaded, so only iss_rd and h1 still block.
  assign hit1   = (head.rs1 != 5'd0) &&
                  ((head.rs1 == iss_q.rd) || (head.rs1 == h1_q));
  assign hit2   = (head.rs2 != 5'd0) &&
                  ((head.rs2 == iss_q.rd) || (head.rs2 == h1_q));
  assign hazard = hit1 || hit2;
  assign pop    = !empty && !hazard;
  assign stall  = !empty && hazard;

  // Next-state for pointers, occupancy and the issue register
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    iss_d   = BUBBLE;
    vld_d   = 1'b0;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
      iss_d  = head;
      vld_d  = 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // FIFO storage; contents need no reset since count guards them
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{
      rs1: in_rs1, rs2: in_rs2, rd: in_rd,
      func: in_func, addr: in_addr
    };
  end

  // Control state, issue register and rd history
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      iss_q   <= BUBBLE;
      vld_q   <= 1'b0;
      h1_q    <= 5'd0;
      h2_q    <= 5'd0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      iss_q   <= iss_d;
      vld_q   <= vld_d;
      h1_q    <= iss_q.rd;
      h2_q    <= h1_q;
    end
  end

  assign iss_valid = vld_q;
  assign iss_rs1   = iss_q.rs1;
  assign iss_rs2   = iss_q.rs2;
  assign iss_rd    = iss_q.rd;
  assign iss_func  = iss_q.func;
  assign iss_addr  = iss_q.addr;
  assign idle      = empty && (iss_q.rd == 5'd0) &&
                     (h1_q == 5'd0) && (h2_q == 5'd0);

`ifdef PIPE_ISSUE_STATS_EN
  logic [31:0] icnt_q, scnt_q;

  // Free-running statistics, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      icnt_q <= '0;
      scnt_q <= '0;
    end else begin
      if (pop)   icnt_q <= icnt_q + 32'd1;
      if (stall) scnt_q <= scnt_q + 32'd1;
    end
  end

  assign issue_count = icnt_q;
  assign stall_count = scnt_q;
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign issue_count  = 32'd0;
  assign stall_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Self-checking bench for pipe_issue_ctrl: directed table, corner
// sequences and random traffic against a timing-based scoreboard.
module tb_pipe_issue_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [3:0]  in_func;
  logic [31:0] in_addr;
  logic        iss_valid;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic [3:0]  iss_func;
  logic [31:0] iss_addr;
  logic        idle;
  logic [31:0] issue_count, stall_count;

  always #5 clk = ~clk;

  pipe_issue_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_func(in_func), .in_addr(in_addr),
    .iss_valid(iss_valid),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_func(iss_func), .iss_addr(iss_addr),
    .idle(idle),
    .issue_count(issue_count), .stall_count(stall_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: queue of pending instructions plus, per architectural
  // register, the edge index at which its pending write lands.
  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  func;
    logic [31:0] addr;
  } ins_t;

  ins_t        mq[$];
  ins_t        m_iss;
  logic        m_vld;
  int          wb[32];
  int          e = 0;
  logic [31:0] m_ic, m_sc;
  bit          m_pushed;

  function automatic ins_t bub();
    ins_t b;
    b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.func = 4'hF; b.addr = 0;
    return b;
  endfunction

  function automatic bit m_idle();
    if (mq.size() != 0) return 0;
    for (int r = 0; r < 32; r++)
      if (wb[r] > e) return 0;
    return 1;
  endfunction

  task automatic model_edge();
    ins_t h;
    ins_t n;
    bit   hz;
    int   sz;
    int   nx;
    m_pushed = 0;
    sz = mq.size();
    nx = e + 1;
    if (reset) begin
      mq.delete();
      m_vld = 0;
      m_iss = bub();
      for (int r = 0; r < 32; r++) wb[r] = 0;
      m_ic = 0;
      m_sc = 0;
    end else begin
      hz = 0;
      if (sz > 0) begin
        h  = mq[0];
        hz = (h.rs1 != 0 && nx < wb[h.rs1]) ||
             (h.rs2 != 0 && nx < wb[h.rs2]);
      end
      if (sz > 0 && !hz) begin
        m_iss = mq.pop_front();
        m_vld = 1;
        m_ic++;
        if (m_iss.rd != 0) wb[m_iss.rd] = nx + 3;
      end else begin
        m_vld = 0;
        m_iss = bub();
        if (sz > 0) m_sc++;
      end
      if (in_valid && sz != DEPTH) begin
        n.rs1 = in_rs1; n.rs2 = in_rs2; n.rd = in_rd;
        n.func = in_func; n.addr = in_addr;
        mq.push_back(n);
        m_pushed = 1;
      end
    end
    e = nx;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("iss_valid", iss_valid, m_vld);
    chk("iss_rs1", iss_rs1, m_iss.rs1);
    chk("iss_rs2", iss_rs2, m_iss.rs2);
    chk("iss_rd", iss_rd, m_iss.rd);
    chk("iss_func", iss_func, m_iss.func);
    chk("iss_addr", iss_addr, m_iss.addr);
    chk("in_ready", in_ready, mq.size() != DEPTH);
    chk("idle", idle, m_idle());
`ifdef PIPE_ISSUE_STATS_EN
    chk("issue_count", issue_count, m_ic);
    chk("stall_count", stall_count, m_sc);
`else
    chk("issue_count", issue_count, 32'd0);
    chk("stall_count", stall_count, 32'd0);
`endif
  endtask

  task automatic drive(logic v, logic [4:0] s1, logic [4:0] s2,
                       logic [4:0] d, logic [3:0] f, logic [31:0] a);
    in_valid = v; in_rs1 = s1; in_rs2 = s2;
    in_rd = d; in_func = f; in_addr = a;
  endtask

  typedef struct {
    logic        rst, vld;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  func;
    logic        ex_vld;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_func;
    logic        ex_idle;
    int          ex_stall;
  } vec_t;

  function automatic vec_t mkv(logic r, logic v, int s1, int s2, int d,
                               int f, logic xv, int xd, int xf,
                               logic xi, int xs);
    vec_t t;
    t.rst = r; t.vld = v;
    t.rs1 = 5'(s1); t.rs2 = 5'(s2); t.rd = 5'(d); t.func = 4'(f);
    t.ex_vld = xv; t.ex_rd = 5'(xd); t.ex_func = 4'(xf);
    t.ex_idle = xi; t.ex_stall = xs;
    return t;
  endfunction

  vec_t tbl[14];

  initial begin
    int  run;
    bit  saw_full;
    int  tries;

    tbl[0]  = mkv(1, 1, 1, 1, 9, 2, 0, 0, 15, 1, 0);
    tbl[1]  = mkv(1, 1, 1, 1, 9, 2, 0, 0, 15, 1, 0);
    tbl[2]  = mkv(0, 1, 1, 2, 5, 2, 0, 0, 15, 0, 0);
    tbl[3]  = mkv(0, 1, 3, 5, 6, 3, 1, 5, 2,  0, 0);
    tbl[4]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 15, 0, 1);
    tbl[5]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 15, 0, 2);
    tbl[6]  = mkv(0, 0, 0, 0, 0, 0, 1, 6, 3,  0, 2);
    tbl[7]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 15, 0, 2);
    tbl[8]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 15, 0, 2);
    tbl[9]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 15, 1, 2);
    tbl[10] = mkv(0, 1, 4, 4, 0, 1, 0, 0, 15, 0, 2);
    tbl[11] = mkv(0, 1, 0, 0, 3, 4, 1, 0, 1,  0, 2);
    tbl[12] = mkv(0, 0, 0, 0, 0, 0, 1, 3, 4,  0, 2);
    tbl[13] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 15, 0, 2);

    for (int r = 0; r < 32; r++) wb[r] = 0;
    m_iss = bub(); m_vld = 0; m_ic = 0; m_sc = 0;

    for (int i = 0; i < 14; i++) begin
      reset = tbl[i].rst;
      drive(tbl[i].vld, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
            tbl[i].func, 32'hA000_0000 + 32'(i));
      step();
      chk($sformatf("tbl%0d_vld", i), iss_valid, tbl[i].ex_vld);
      chk($sformatf("tbl%0d_rd", i), iss_rd, tbl[i].ex_rd);
      chk($sformatf("tbl%0d_func", i), iss_func, tbl[i].ex_func);
      chk($sformatf("tbl%0d_idle", i), idle, tbl[i].ex_idle);
`ifdef PIPE_ISSUE_STATS_EN
      chk($sformatf("tbl%0d_stall", i), stall_count, tbl[i].ex_stall);
`endif
    end

    // Independent stream: four issues back to back
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      step();
    end
    run = 0;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 5'(10 + i), 5'(10 + i), 5'(i), 4'(i), 32'(100 + i));
      step();
      if (iss_valid) run++;
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (iss_valid) run++;
    end
    chk("indep_run", run, 4);

    // Full FIFO with a dependency chain
    saw_full = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, (i == 0) ? 5'd0 : 5'(6 + i), 5'd0, 5'(7 + i), 4'd5,
            32'(200 + i));
      tries = 0;
      do begin
        step();
        if (!in_ready) saw_full = 1;
        tries++;
      end while (!m_pushed && tries < 20);
      chk($sformatf("chain%0d_accept", i), m_pushed, 1'b1);
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) step();
    chk("full_seen", saw_full, 1'b1);
    chk("chain_drained", idle, 1'b1);

    // Reset with a hazard chain queued
    for (int i = 0; i < 4; i++) begin
      drive(1, (i == 0) ? 5'd0 : 5'(6 + i), 5'd0, 5'(7 + i), 4'd6,
            32'(300 + i));
      step();
    end
    reset = 1;
    drive(1, 5'd1, 5'd1, 5'd20, 4'd7, 32'hDEAD);
    step();
    chk("rst_mid_idle", idle, 1'b1);
    chk("rst_mid_vld", iss_valid, 1'b0);
    reset = 0;
    drive(1, 5'd2, 5'd2, 5'd21, 4'd8, 32'hBEEF);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("rst_fresh_vld", iss_valid, 1'b1);
    chk("rst_fresh_addr", iss_addr, 32'hBEEF);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 3) != 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 4'($urandom),
            32'($urandom));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
